// File: rtl/parity_circuit_tester_pkg.sv
// Shared types and helpers for the evolved-circuit parity testers.
// Holds the tester state encoding, the golden parity function and the settle floor.
package parity_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    NEXT,
    DONE
  } state_t;

  // Two synchroniser flops plus one cycle of margin before a sample is trusted
  localparam int MIN_SETTLE = 3;

  function automatic logic golden_parity(input logic [7:0] vec, input logic invert);
    return (^vec) ^ invert;
  endfunction

endpackage

// File: rtl/parity_circuit_tester_if.sv
// Bundle between the evolution controller, the parity tester and one evolved circuit.
// The slave side is the tester; the master side is everything around it.
interface parity_circuit_tester_if #(
  parameter int N_INPUTS = 3,
  parameter int REPEATS  = 1
);

  localparam int V     = 2 ** N_INPUTS;
  localparam int ERR_W = $clog2(V * REPEATS + 1);

  logic                start;
  logic                abort;
  logic [N_INPUTS-1:0] dut_in;
  logic                dut_out;
  logic                busy;
  logic                done;
  logic [ERR_W-1:0]    error_cnt;
  logic [V-1:0]        fail_map;

  modport master (
    output start,
    output abort,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  error_cnt,
    input  fail_map
  );

  modport slave (
    input  start,
    input  abort,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output error_cnt,
    output fail_map
  );

endinterface

// File: rtl/parity_circuit_tester_settle_timer.sv
// Down-counter giving each driven vector a fixed settle window before sampling.
// Load restarts the window; zero flags that the window has elapsed.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int            W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [W-1:0]  LOAD_VAL = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt;

  // Counts down to zero and parks there until the next load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/parity_circuit_tester.sv
// Sweeps every input vector into an evolved parity circuit and scores its output.
// Produces a mismatch count and a per-vector fail map for fitness evaluation.
module parity_circuit_tester
  import parity_test_pkg::*;
#(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int REPEATS       = 1,
  parameter int INVERT        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  parity_circuit_tester_if.slave  bus
);

  localparam int                  V          = 2 ** N_INPUTS;
  localparam int                  ERR_W      = $clog2(V * REPEATS + 1);
  localparam int                  EFF_SETTLE = (SETTLE_CYCLES < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYCLES;
  localparam logic [N_INPUTS-1:0] VEC_LAST   = N_INPUTS'(V - 1);
  localparam logic [3:0]          REP_LAST   = 4'(REPEATS - 1);
  localparam logic                INV_BIT    = (INVERT != 0);

  state_t              state;
  state_t              state_next;
  logic [N_INPUTS-1:0] vec;
  logic [3:0]          rep;
  logic                sync_meta;
  logic                sync_out;
  logic                timer_load;
  logic                timer_zero;

  settle_timer #(
    .SETTLE_CYCLES(EFF_SETTLE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .zero (timer_zero)
  );

  // The circuit output is unclocked and may glitch, so only the resynchronised copy is scored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= bus.dut_out;
      sync_out  <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every transition into DRIVE reloads the settle window
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = DRIVE;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (timer_zero) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        state_next = bus.abort ? IDLE : NEXT;
      end
      NEXT: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (vec == VEC_LAST && rep == REP_LAST) begin
          state_next = DONE;
        end else begin
          state_next = DRIVE;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Abort keeps partial scores but releases the circuit and never pulses done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec           <= '0;
      rep           <= '0;
      bus.dut_in    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error_cnt <= '0;
      bus.fail_map  <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        bus.busy   <= 1'b0;
        bus.dut_in <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              vec           <= '0;
              rep           <= '0;
              bus.dut_in    <= '0;
              bus.busy      <= 1'b1;
              bus.error_cnt <= '0;
              bus.fail_map  <= '0;
            end
          end
          SAMPLE: begin
            if (sync_out != golden_parity(8'(vec), INV_BIT)) begin
              bus.fail_map[vec] <= 1'b1;
              if (bus.error_cnt != '1) begin
                bus.error_cnt <= bus.error_cnt + ERR_W'(1);
              end
            end
          end
          NEXT: begin
            if (vec != VEC_LAST) begin
              vec        <= vec + N_INPUTS'(1);
              bus.dut_in <= vec + N_INPUTS'(1);
            end else if (rep != REP_LAST) begin
              vec        <= '0;
              rep        <= rep + 4'd1;
              bus.dut_in <= '0;
            end
          end
          DONE: begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_circuit_tester.sv
// Bench for parity_circuit_tester: two tester instances driven by modelled evolved circuits.
// Instance a uses the defaults; instance b runs two sweeps, XNOR golden and the minimum settle.
module tb_parity_circuit_tester;

  typedef struct packed {
    bit         stuck;
    bit         stuck_val;
    bit         dut_pol;
    logic [7:0] mask;
    bit         late5;
  } cfg_t;

  typedef struct {
    string name;
    bit    inst;
    cfg_t  cfg;
    bit    extra_starts;
    int    exp_errs;
    int    exp_map;
    int    exp_lat;
  } vec_rec_t;

  logic clk;
  logic rst;
  cfg_t cfg_a;
  cfg_t cfg_b;
  int   visit_b;
  logic [2:0] prev_in_b;
  int   check_count;
  int   error_count;

  parity_circuit_tester_if #(.N_INPUTS(3), .REPEATS(1)) bus_a ();
  parity_circuit_tester_if #(.N_INPUTS(3), .REPEATS(2)) bus_b ();

  parity_circuit_tester #(
    .N_INPUTS(3), .SETTLE_CYCLES(4), .REPEATS(1), .INVERT(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  parity_circuit_tester #(
    .N_INPUTS(3), .SETTLE_CYCLES(3), .REPEATS(2), .INVERT(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modelled evolved circuits: ideal parity with optional polarity flip, per-vector faults or a stuck output
  always_comb begin
    if (cfg_a.stuck) bus_a.dut_out = cfg_a.stuck_val;
    else             bus_a.dut_out = (^bus_a.dut_in) ^ cfg_a.dut_pol ^ cfg_a.mask[bus_a.dut_in];
  end

  always_comb begin
    if (cfg_b.stuck) bus_b.dut_out = cfg_b.stuck_val;
    else             bus_b.dut_out = (^bus_b.dut_in) ^ cfg_b.dut_pol ^ cfg_b.mask[bus_b.dut_in]
                                     ^ (cfg_b.late5 && visit_b == 2 && bus_b.dut_in == 3'd5);
  end

  // Counts how many sweeps have reached vector 5, so a fault can appear only on the second one
  always @(negedge clk) begin
    if (!bus_b.busy)                                    visit_b <= 0;
    else if (bus_b.dut_in == 3'd5 && prev_in_b != 3'd5) visit_b <= visit_b + 1;
    prev_in_b <= bus_b.dut_in;
  end

  function automatic cfg_t mk_cfg(input bit stuck, input bit sv, input bit pol, input logic [7:0] mask, input bit late5);
    cfg_t c;
    c.stuck     = stuck;
    c.stuck_val = sv;
    c.dut_pol   = pol;
    c.mask      = mask;
    c.late5     = late5;
    return c;
  endfunction

  // Reference: enumerate every sweep and vector, compare modelled circuit against the parity rule
  function automatic void ref_model(input int repeats, input bit inv, input cfg_t c, output int errs, output int map);
    bit par;
    bit observed;
    errs = 0;
    map  = 0;
    for (int r = 0; r < repeats; r++) begin
      for (int v = 0; v < 8; v++) begin
        par = ($countones(v) % 2) == 1;
        if (c.stuck) observed = c.stuck_val;
        else         observed = par ^ c.dut_pol ^ c.mask[v] ^ (c.late5 && r == 1 && v == 5);
        if (observed != (par ^ inv)) begin
          errs++;
          map = map | (1 << v);
        end
      end
    end
  endfunction

  function automatic int busy_of(input bit inst);
    return inst ? int'(bus_b.busy) : int'(bus_a.busy);
  endfunction

  function automatic int done_of(input bit inst);
    return inst ? int'(bus_b.done) : int'(bus_a.done);
  endfunction

  function automatic int err_of(input bit inst);
    return inst ? int'(bus_b.error_cnt) : int'(bus_a.error_cnt);
  endfunction

  function automatic int map_of(input bit inst);
    return inst ? int'(bus_b.fail_map) : int'(bus_a.fail_map);
  endfunction

  task automatic drive_start(input bit inst, input bit v);
    if (inst) bus_b.start = v;
    else      bus_a.start = v;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // One full run: start, optional stray starts mid-run, wait for done and score the results
  task automatic applyStimulus(input string name, input bit inst, input cfg_t c, input bit extra_starts,
                               input int exp_errs, input int exp_map, input int exp_lat);
    int cnt;
    int dn;
    if (inst) cfg_b = c;
    else      cfg_a = c;
    @(negedge clk);
    drive_start(inst, 1'b1);
    @(posedge clk);
    #1;
    drive_start(inst, 1'b0);
    cnt = 1;
    checkOutput({name, "_busy"}, busy_of(inst), 1);
    dn = done_of(inst);
    while (dn == 0 && cnt < 1000) begin
      drive_start(inst, extra_starts && (cnt == 10 || cnt == 30));
      @(posedge clk);
      #1;
      cnt++;
      dn = done_of(inst);
    end
    drive_start(inst, 1'b0);
    checkOutput({name, "_latency"}, cnt, exp_lat);
    checkOutput({name, "_error_cnt"}, err_of(inst), exp_errs);
    checkOutput({name, "_fail_map"}, map_of(inst), exp_map);
    checkOutput({name, "_busy_end"}, busy_of(inst), 0);
    @(posedge clk);
    #1;
    checkOutput({name, "_done_pulse"}, done_of(inst), 0);
  endtask

  vec_rec_t table_v[7];

  initial begin
    int   cnt;
    int   seen;
    int   e;
    int   m;
    bit   inst;
    cfg_t c;

    check_count = 0;
    error_count = 0;
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;
    cfg_a       = mk_cfg(0, 0, 0, 8'h00, 0);
    cfg_b       = mk_cfg(0, 0, 1, 8'h00, 0);

    table_v[0] = '{"xor_ideal",   1'b0, mk_cfg(0, 0, 0, 8'h00, 0), 1'b0, 0, 8'h00, 50};
    table_v[1] = '{"xnor_on_xor", 1'b0, mk_cfg(0, 0, 1, 8'h00, 0), 1'b1, 8, 8'hFF, 50};
    table_v[2] = '{"stuck0",      1'b0, mk_cfg(1, 0, 0, 8'h00, 0), 1'b0, 4, 8'h96, 50};
    table_v[3] = '{"stuck1",      1'b0, mk_cfg(1, 1, 0, 8'h00, 0), 1'b0, 4, 8'h69, 50};
    table_v[4] = '{"xnor_golden", 1'b1, mk_cfg(0, 0, 1, 8'h00, 0), 1'b0, 0, 8'h00, 82};
    table_v[5] = '{"late_vec5",   1'b1, mk_cfg(0, 0, 1, 8'h00, 1), 1'b0, 1, 8'h20, 82};
    table_v[6] = '{"b_stuck0",    1'b1, mk_cfg(1, 0, 0, 8'h00, 0), 1'b1, 8, 8'h69, 82};

    #23;
    checkOutput("reset_busy_a", int'(bus_a.busy), 0);
    checkOutput("reset_dut_in_a", int'(bus_a.dut_in), 0);
    checkOutput("reset_err_b", int'(bus_b.error_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_done_a", int'(bus_a.done), 0);
    checkOutput("idle_map_a", int'(bus_a.fail_map), 0);
    checkOutput("idle_busy_b", int'(bus_b.busy), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(table_v[i].name, table_v[i].inst, table_v[i].cfg, table_v[i].extra_starts,
                    table_v[i].exp_errs, table_v[i].exp_map, table_v[i].exp_lat);
    end

    for (int k = 0; k < 8; k++) begin
      inst = k[0];
      c    = mk_cfg(0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0);
      ref_model(inst ? 2 : 1, inst, c, e, m);
      applyStimulus($sformatf("rand%0d", k), inst, c, 1'b0, e, m, inst ? 82 : 50);
    end

    // Abort while vector 3 is being driven; the vector-1 fault must stay recorded
    cfg_a = mk_cfg(0, 0, 0, 8'h02, 0);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    cnt = 0;
    while (bus_a.dut_in != 3'd3 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("abort_reached_vec3", int'(bus_a.dut_in == 3'd3), 1);
    bus_a.abort = 1'b1;
    @(posedge clk);
    #1;
    bus_a.abort = 1'b0;
    checkOutput("abort_busy", int'(bus_a.busy), 0);
    checkOutput("abort_dut_in", int'(bus_a.dut_in), 0);
    checkOutput("abort_done", int'(bus_a.done), 0);
    checkOutput("abort_err_kept", int'(bus_a.error_cnt), 1);
    checkOutput("abort_map_kept", int'(bus_a.fail_map), 8'h02);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.done || bus_a.busy) seen = 1;
    end
    checkOutput("abort_no_done", seen, 0);
    applyStimulus("after_abort", 1'b0, mk_cfg(0, 0, 0, 8'h00, 0), 1'b0, 0, 8'h00, 50);

    // Start and abort together in IDLE: nothing starts
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    checkOutput("start_abort_idle_busy", int'(bus_a.busy), 0);
    @(posedge clk);
    #1;
    checkOutput("start_abort_idle_busy2", int'(bus_a.busy), 0);

    // Reset between clock edges in the middle of a faulty sweep
    cfg_a = mk_cfg(0, 0, 0, 8'hFF, 0);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_err", int'(bus_a.error_cnt), 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", int'(bus_a.busy), 0);
    checkOutput("async_rst_dut_in", int'(bus_a.dut_in), 0);
    checkOutput("async_rst_err", int'(bus_a.error_cnt), 0);
    checkOutput("async_rst_map", int'(bus_a.fail_map), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.done || bus_a.busy) seen = 1;
    end
    checkOutput("reset_no_done", seen, 0);
    applyStimulus("after_reset", 1'b0, mk_cfg(0, 0, 0, 8'h00, 0), 1'b0, 0, 8'h00, 50);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
